// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and states for the cpu/DMA RAM port arbiter
package mem_arb_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam int DEF_MAX_WAIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DACC = 2'b01,
    DRD  = 2'b10
  } arb_state_t;

  // Encoding 11 is illegal and treated exactly like no command.
  function automatic logic cmd_busy(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// rtl/mem_arb_wait_ctr.sv - saturating up-counter with clear priority over increment
module mem_arb_wait_ctr #(
  parameter int          W   = 4,
  parameter int unsigned MAX = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  assign at_max = (count == MAXV);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - cpu-priority RAM port arbiter with forced DMA grant after MAX_WAIT
// Optional grant statistics outputs are enabled by defining MEM_ARB_STATS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 9,
  parameter int DW       = 16,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cpu_mem_cmd,
  input  logic [AW-1:0] cpu_mem_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_hold,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_grants,
  output logic [15:0]   stat_forced
`endif
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  arb_state_t    state, state_nx;
  logic          cpu_busy;
  logic          go;
  logic          force_grant;
  logic [WW-1:0] wait_cnt;
  logic          wait_max;
  logic          wait_inc;
  logic          wait_clr;
  logic          cap_we;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic [DW-1:0] rdata_hold;
  logic          in_dacc;
  logic          in_drd;

  assign cpu_busy = cmd_busy(cpu_mem_cmd);
  assign in_dacc  = (state == DACC);
  assign in_drd   = (state == DRD);

  // Nonzero guard keeps a degenerate MAX_WAIT=0 from forcing on every cycle.
  assign force_grant = wait_max && (wait_cnt != '0);
  assign go          = (state == IDLE) && dma_req && (!cpu_busy || force_grant);

  assign wait_inc = (state == IDLE) && dma_req && cpu_busy && !go;
  assign wait_clr = go || !dma_req;

  mem_arb_wait_ctr #(
    .W   (WW),
    .MAX (MAX_WAIT)
  ) u_wait_ctr (
    .clk    (clk),
    .reset  (reset),
    .inc    (wait_inc),
    .clr    (wait_clr),
    .count  (wait_cnt),
    .at_max (wait_max)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = DACC;
      DACC:    state_nx = cap_we ? IDLE : DRD;
      DRD:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (go) begin
      cap_we    <= dma_we;
      cap_addr  <= dma_addr;
      cap_wdata <= dma_wdata;
    end
  end

  // RAM data arrives in DRD; it is forwarded that cycle and held afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_hold <= '0;
    end else if (in_drd) begin
      rdata_hold <= ram_rdata;
    end
  end

  assign cpu_hold   = in_dacc;
  assign dma_gnt    = in_dacc;
  assign dma_rvalid = in_drd;
  assign dma_rdata  = in_drd ? ram_rdata : rdata_hold;
  assign cpu_rdata  = ram_rdata;

  assign ram_addr  = in_dacc ? cap_addr  : cpu_mem_addr;
  assign ram_wdata = in_dacc ? cap_wdata : cpu_wdata;
  assign ram_we    = in_dacc ? cap_we    : (cpu_mem_cmd == MWRITE);

`ifdef MEM_ARB_STATS_EN
  logic grants_full;
  logic forced_full;

  mem_arb_wait_ctr #(
    .W   (16),
    .MAX (16'hFFFF)
  ) u_stat_grants (
    .clk    (clk),
    .reset  (reset),
    .inc    (go),
    .clr    (1'b0),
    .count  (stat_grants),
    .at_max (grants_full)
  );

  mem_arb_wait_ctr #(
    .W   (16),
    .MAX (16'hFFFF)
  ) u_stat_forced (
    .clk    (clk),
    .reset  (reset),
    .inc    (go && cpu_busy),
    .clr    (1'b0),
    .count  (stat_forced),
    .at_max (forced_full)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter with DMA read scoreboard
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_RD   = 2'b01;
  localparam logic [1:0] C_WR   = 2'b10;
  localparam logic [1:0] C_ILL  = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    cpu_mem_cmd;
  logic [AW-1:0] cpu_mem_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_hold;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]   stat_grants;
  logic [15:0]   stat_forced;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;
  int exp_grants = 0;
  int exp_forced = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_mem_cmd  (cpu_mem_cmd),
    .cpu_mem_addr (cpu_mem_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_hold     (cpu_hold),
    .dma_req      (dma_req),
    .dma_we       (dma_we),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wdata),
    .dma_gnt      (dma_gnt),
    .dma_rvalid   (dma_rvalid),
    .dma_rdata    (dma_rdata),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_grants  (stat_grants),
    .stat_forced  (stat_forced)
`endif
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats();
`ifdef MEM_ARB_STATS_EN
    chk("stat_grants", {16'h0, stat_grants}, exp_grants);
    chk("stat_forced", {16'h0, stat_forced}, exp_forced);
`endif
  endtask

  // One cycle forward; any dma_rvalid is matched against the scoreboard.
  task automatic cyc();
    logic [DW-1:0] e;
    @(negedge clk);
    if (dma_rvalid) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dma_rdata", {16'h0, dma_rdata}, {16'h0, e});
      end else begin
        chk("rvalid_spurious", {31'h0, dma_rvalid}, 32'h0);
      end
    end
  endtask

  task automatic dma_set(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  task automatic cpu_set(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_mem_cmd = c; cpu_mem_addr = a; cpu_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    ram_rdata = '0;
    reset = 1'b0;
    cpu_set(C_NONE, '0, '0);
    dma_set(1'b0, 1'b0, '0, '0);
    cyc(); cyc();
    chk("rst_hold", cpu_hold, 0);
    chk("rst_gnt", dma_gnt, 0);
    chk("rst_rvalid", dma_rvalid, 0);
    chk("rst_rdata", dma_rdata, 0);
    chk("rst_ram_we", ram_we, 0);
    chk_stats();
    reset = 1'b1;

    // DMA write with cpu idle
    dma_set(1'b1, 1'b1, 9'h005, 16'hBEEF);
    cyc();
    exp_grants++;
    chk("wr_gnt", dma_gnt, 1);
    chk("wr_hold", cpu_hold, 1);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 9'h005);
    chk("wr_ram_wdata", ram_wdata, 16'hBEEF);
    dma_req = 1'b0;
    cyc();
    chk("wr_gnt_1cyc", dma_gnt, 0);
    chk("wr_hold_1cyc", cpu_hold, 0);

    // DMA read of the same word
    dma_set(1'b1, 1'b0, 9'h005, 16'h0000);
    exp_q.push_back(16'hBEEF);
    cyc();
    exp_grants++;
    chk("rd_gnt", dma_gnt, 1);
    chk("rd_ram_we", ram_we, 0);
    dma_req = 1'b0;
    cyc();
    chk("rd_rvalid", dma_rvalid, 1);
    cyc();
    chk("rd_rvalid_pulse", dma_rvalid, 0);
    chk("rd_rdata_hold", dma_rdata, 16'hBEEF);

    // cpu read back
    cpu_set(C_RD, 9'h005, '0);
    cyc();
    chk("cpu_rd", cpu_rdata, 16'hBEEF);
    chk_stats();

    // Continuous cpu reads: forced grant after MAX_WAIT
    dma_set(1'b1, 1'b1, 9'h030, 16'h1234);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("force_early_gnt", dma_gnt, 0);
      chk("force_cpu_rd", cpu_rdata, 16'hBEEF);
    end
    cyc();
    exp_grants++; exp_forced++;
    chk("force_gnt", dma_gnt, 1);
    chk("force_hold", cpu_hold, 1);
    chk("force_ram_addr", ram_addr, 9'h030);
    chk("force_ram_we", ram_we, 1);
    dma_req = 1'b0;
    cyc();
    chk("force_hold_drop", cpu_hold, 0);
    cyc();
    chk("force_cpu_rd_after", cpu_rdata, 16'hBEEF);
    chk_stats();
    cpu_set(C_NONE, '0, '0);

    // cpu write presented during DACC is deferred
    dma_set(1'b1, 1'b1, 9'h040, 16'h5555);
    cyc();
    exp_grants++;
    cpu_set(C_WR, 9'h010, 16'hABCD);
    dma_req = 1'b0;
    #1;
    chk("blk_ram_addr", ram_addr, 9'h040);
    chk("blk_ram_wdata", ram_wdata, 16'h5555);
    cyc();
    chk("blk_mem_untouched", mem[9'h010], 16'h0000);
    chk("blk_ram_we_cpu", ram_we, 1);
    chk("blk_ram_addr_cpu", ram_addr, 9'h010);
    chk("blk_ram_wdata_cpu", ram_wdata, 16'hABCD);
    cyc();
    cpu_set(C_RD, 9'h010, '0);
    cyc();
    chk("blk_cpu_rd", cpu_rdata, 16'hABCD);
    cpu_set(C_RD, 9'h040, '0);
    cyc();
    chk("blk_dma_word", cpu_rdata, 16'h5555);

    // Request dropped before grant: wait count restarts
    dma_set(1'b1, 1'b1, 9'h050, 16'h5A5A);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("drop_no_gnt", dma_gnt, 0);
    end
    dma_req = 1'b0;
    cyc();
    chk("drop_no_gnt2", dma_gnt, 0);
    chk_stats();
    dma_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("rearm_early_gnt", dma_gnt, 0);
    end
    cyc();
    exp_grants++; exp_forced++;
    chk("rearm_gnt", dma_gnt, 1);
    chk("rearm_ram_addr", ram_addr, 9'h050);
    dma_req = 1'b0;
    cpu_set(C_NONE, '0, '0);
    cyc();
    chk_stats();

    // Illegal cpu command counts as idle and never writes
    cpu_set(C_ILL, 9'h060, 16'hFFFF);
    dma_set(1'b1, 1'b0, 9'h005, 16'h0000);
    exp_q.push_back(16'hBEEF);
    #1;
    chk("ill_ram_we", ram_we, 0);
    cyc();
    exp_grants++;
    chk("ill_gnt", dma_gnt, 1);
    dma_req = 1'b0;
    cpu_set(C_RD, 9'h010, '0);
    cyc();
    chk("ill_rvalid", dma_rvalid, 1);
    cyc();
    chk("drd_cpu_rd", cpu_rdata, 16'hABCD);
    chk("ill_mem_untouched", mem[9'h060], 16'h0000);
    cpu_set(C_NONE, '0, '0);
    chk_stats();

    // Async reset mid DMA read
    dma_set(1'b1, 1'b0, 9'h005, 16'h0000);
    cyc();
    chk("rstx_gnt", dma_gnt, 1);
    reset = 1'b0;
    #1;
    chk("rstx_hold", cpu_hold, 0);
    chk("rstx_gnt0", dma_gnt, 0);
    chk("rstx_ram_we", ram_we, 0);
    dma_req = 1'b0;
    cyc();
    chk("rstx_rvalid", dma_rvalid, 0);
    exp_grants = 0; exp_forced = 0;
    chk_stats();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rstx_no_rvalid", dma_rvalid, 0);
    end
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 16-bit data/instruction RAM between the cpu memory port (mem_cmd/mem_addr/write_data/read_data) and a secondary DMA/loader requester (program loader, debug reader).
- CPU has priority. The DMA is served in cycles where the CPU issues no command.
- When the DMA has waited MAX_WAIT cycles, the arbiter forces a one-cycle cpu_hold (wired to the cpu clock-enable) and serves the DMA.
- Sits between cpu and RAM.

Parameters:
- AW, 9, address width (matches mem_addr).
- DW, 16, data width.
- MAX_WAIT, 8, DMA pending cycles before a forced grant (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_mem_cmd  in  2  00 none, 01 MREAD, 10 MWRITE, 11 treated as none.
- cpu_mem_addr  in  AW  cpu address.
- cpu_wdata  in  DW  cpu write data.
- cpu_rdata  out  DW  RAM read data to cpu (passthrough of ram_rdata).
- cpu_hold  out  1  freezes cpu for the current cycle.
- dma_req  in  1  level request; dma_we/addr/wdata stable until dma_gnt.
- dma_we  in  1  1 write, 0 read.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_gnt  out  1  one-cycle pulse, DMA access on RAM this cycle.
- dma_rvalid  out  1  one-cycle pulse, dma_rdata valid.
- dma_rdata  out  DW  read data.
- ram_addr  out  AW  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  registered RAM read data, valid 1 cycle after address.

Behaviour:
- States are IDLE, DACC and DRD. Reset value: IDLE, all outputs 0, wait_cnt 0, captured DMA registers 0.
- IDLE → DACC when dma_req and either the cpu command is none or wait_cnt==MAX_WAIT. On this transition dma_we/addr/wdata are captured. Otherwise stay in IDLE.
- DACC → DRD if the captured we=0, else → IDLE.
- DRD → IDLE always. The DMA cannot be granted in DRD, so the minimum DMA spacing is 2 cycles for writes and 3 for reads.
- cpu_hold and dma_gnt are registered and both equal (state==DACC).
- ram_addr/ram_wdata/ram_we come from the captured DMA registers in DACC, else from the cpu. ram_we = (cpu_mem_cmd==10) outside DACC, and the captured we in DACC. A cpu write during DACC is blocked because the cpu is held and re-presents it next cycle.
- cpu_rdata = ram_rdata combinationally in all states.
- dma_rdata is registered: it captures ram_rdata and dma_rvalid=1 in DRD; otherwise dma_rvalid=0 and dma_rdata holds its value.
- wait_cnt:
  - Increments in IDLE when dma_req=1 and the cpu is busy, saturating at MAX_WAIT.
  - Clears on entry to DACC or whenever dma_req=0.
  - Width = clog2(MAX_WAIT+1).
- A DMA read returns data the cycle after DACC. A cpu read issued in DRD gets its data in the following cycle, unaffected.
- A dma_req drop before grant is legal: no grant occurs and wait_cnt clears.
- A dma_req drop after grant does not cancel the transaction.
- Async reset mid-transaction returns to IDLE immediately. The pending DMA access is dropped with no dma_rvalid, and any in-flight ram_we deasserts.
- Illegal cpu_mem_cmd 11 counts as idle for arbitration and never writes.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined: adds outputs stat_grants[15:0] (DMA grants) and stat_forced[15:0] (grants made with the cpu busy, i.e. forced holds). Both saturate at FFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds the MNONE/MREAD/MWRITE encodings (2'b00/01/10), the state enum (IDLE/DACC/DRD) and the default MAX_WAIT.
- Sub-module mem_arb_wait_ctr: saturating wait counter with inc/clr inputs and an at_max output. It is reused for the stat counters.

Test Plan:
- Reset low mid-DACC with dma_we=0 → next cycle state IDLE, dma_rvalid never pulses, cpu_hold=0, ram_we=0.
- CPU idle, dma_req with we=1, addr 0x05, wdata 0xBEEF → dma_gnt and cpu_hold high for exactly 1 cycle, ram_we=1, ram_addr=0x05; a later read of 0x05 returns 0xBEEF.
- CPU idle, DMA read of addr 0x05 → gnt in cycle t, dma_rvalid=1 with dma_rdata=0xBEEF in t+1.
- CPU issues continuous MREAD, dma_req held, MAX_WAIT=8 → forced gnt exactly 9 cycles after req; cpu_hold for 1 cycle; cpu reads before and after are unaffected. With stats enabled, stat_forced=1.
- CPU MWRITE to 0x10 presented during DACC → RAM not written that cycle; written with cpu data on the next cycle after hold drops.
- dma_req raised then dropped while the cpu is busy → no dma_gnt, wait_cnt returns to 0, stat_grants unchanged.
